// File: rtl/core_pkg.sv
// Shared core types plus trap-sequencer constants, state encoding and CSR address helper.
package core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CODE_W     = 5;
    localparam int unsigned CSR_ADDR_W = 12;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [CODE_W-1:0] {
        EXC_INSTR_MISALIGNED = 5'd0,
        EXC_INSTR_ACCESS     = 5'd1,
        EXC_ILLEGAL_INSTR    = 5'd2,
        EXC_BREAKPOINT       = 5'd3,
        EXC_LOAD_MISALIGNED  = 5'd4,
        EXC_LOAD_ACCESS      = 5'd5,
        EXC_STORE_MISALIGNED = 5'd6,
        EXC_STORE_ACCESS     = 5'd7,
        EXC_ECALL_U          = 5'd8,
        EXC_ECALL_S          = 5'd9,
        EXC_ECALL_M          = 5'd11,
        EXC_INSTR_PAGE       = 5'd12,
        EXC_LOAD_PAGE        = 5'd13,
        EXC_STORE_PAGE       = 5'd15
    } exception_e;

    typedef enum logic [CODE_W-1:0] {
        INT_S_SOFT  = 5'd1,
        INT_M_SOFT  = 5'd3,
        INT_S_TIMER = 5'd5,
        INT_M_TIMER = 5'd7,
        INT_S_EXT   = 5'd9,
        INT_M_EXT   = 5'd11
    } interrupt_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EPC      = 3'd1,
        CAUSE    = 3'd2,
        TVAL     = 3'd3,
        STATUS   = 3'd4,
        REDIRECT = 3'd5
    } trap_state_e;

    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC   = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL  = 12'h343;
    localparam logic [CSR_ADDR_W-1:0] CSR_SEPC   = 12'h141;
    localparam logic [CSR_ADDR_W-1:0] CSR_SCAUSE = 12'h142;
    localparam logic [CSR_ADDR_W-1:0] CSR_STVAL  = 12'h143;

    localparam logic [1:0] TVEC_MODE_VECTORED = 2'b01;

    // CSR written in a given write state, banked by trap target.
    function automatic logic [CSR_ADDR_W-1:0] trap_csr_addr(input trap_state_e st, input logic to_s);
        logic [CSR_ADDR_W-1:0] addr;
        addr = '0;
        case (st)
            EPC:     addr = to_s ? CSR_SEPC   : CSR_MEPC;
            CAUSE:   addr = to_s ? CSR_SCAUSE : CSR_MCAUSE;
            TVAL:    addr = to_s ? CSR_STVAL  : CSR_MTVAL;
            default: addr = '0;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/core_trap_select.sv
// Trap source priority, delegation and cause-word formation (purely combinational).
module core_trap_select
    import core_pkg::*;
(
    input  logic              exception_valid,
    input  exception_e        exception_cause,
    input  logic [XLEN-1:0]   exception_value,
    input  logic              m_interrupt_valid,
    input  interrupt_e        m_interrupt_cause,
    input  logic              s_interrupt_valid,
    input  interrupt_e        s_interrupt_cause,
    input  priv_e             priv,
    input  logic [XLEN-1:0]   medeleg,
    input  logic [XLEN-1:0]   mideleg,
    output logic              sel_valid_c,
    output logic              sel_to_s_c,
    output logic [XLEN-1:0]   sel_cause_c,
    output logic [XLEN-1:0]   sel_tval_c
);

    logic              is_int;
    logic [CODE_W-1:0] code;

    // M-interrupt beats S-interrupt beats exception; M-interrupts never delegate.
    always_comb begin
        sel_valid_c = m_interrupt_valid | s_interrupt_valid | exception_valid;
        is_int      = 1'b0;
        code        = '0;
        sel_to_s_c  = 1'b0;
        sel_tval_c  = '0;
        if (m_interrupt_valid) begin
            is_int = 1'b1;
            code   = CODE_W'(m_interrupt_cause);
        end else if (s_interrupt_valid) begin
            is_int     = 1'b1;
            code       = CODE_W'(s_interrupt_cause);
            sel_to_s_c = mideleg[code];
        end else if (exception_valid) begin
            code       = CODE_W'(exception_cause);
            sel_tval_c = exception_value;
            sel_to_s_c = (priv != PRIV_M) && medeleg[code];
        end
        sel_cause_c = {is_int, {(XLEN-1-CODE_W){1'b0}}, code};
    end

endmodule

// File: rtl/core_trap_sequencer.sv
// Trap entry sequencer: writes xEPC/xCAUSE/xTVAL, pulses the status stack update,
// then redirects fetch to xTVEC. Define TRAP_VECTORED_EN for vectored interrupts.
module core_trap_sequencer
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trap_req,
    input  logic                  exception_valid,
    input  exception_e            exception_cause,
    input  logic [XLEN-1:0]       exception_value,
    input  logic                  m_interrupt_valid,
    input  logic                  s_interrupt_valid,
    input  interrupt_e            m_interrupt_cause,
    input  interrupt_e            s_interrupt_cause,
    input  logic [XLEN-1:0]       pc,
    input  priv_e                 priv,
    input  logic [XLEN-1:0]       medeleg,
    input  logic [XLEN-1:0]       mideleg,
    input  logic [XLEN-1:0]       mtvec,
    input  logic [XLEN-1:0]       stvec,
    output logic                  csr_wr_valid,
    output logic [CSR_ADDR_W-1:0] csr_wr_addr,
    output logic [XLEN-1:0]       csr_wr_data,
    input  logic                  csr_wr_ready,
    output logic                  status_trap_valid,
    output logic                  status_trap_to_s,
    output priv_e                 priv_new,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  busy,
    output logic                  trap_done
);

    logic            sel_valid_c;
    logic            sel_to_s_c;
    logic [XLEN-1:0] sel_cause_c;
    logic [XLEN-1:0] sel_tval_c;

    core_trap_select u_select (
        .exception_valid   (exception_valid),
        .exception_cause   (exception_cause),
        .exception_value   (exception_value),
        .m_interrupt_valid (m_interrupt_valid),
        .m_interrupt_cause (m_interrupt_cause),
        .s_interrupt_valid (s_interrupt_valid),
        .s_interrupt_cause (s_interrupt_cause),
        .priv              (priv),
        .medeleg           (medeleg),
        .mideleg           (mideleg),
        .sel_valid_c       (sel_valid_c),
        .sel_to_s_c        (sel_to_s_c),
        .sel_cause_c       (sel_cause_c),
        .sel_tval_c        (sel_tval_c)
    );

    trap_state_e           state_q, state_d;
    logic                  cap_to_s_q, cap_to_s_d;
    logic [XLEN-1:0]       cap_cause_q, cap_cause_d;
    logic [XLEN-1:0]       cap_tval_q, cap_tval_d;
    logic [XLEN-1:0]       cap_pc_q, cap_pc_d;

    logic                  csr_wr_valid_d;
    logic [CSR_ADDR_W-1:0] csr_wr_addr_d;
    logic [XLEN-1:0]       csr_wr_data_d;
    logic                  status_trap_valid_d;
    logic                  status_trap_to_s_d;
    priv_e                 priv_new_d;
    logic                  redirect_valid_d;
    logic [XLEN-1:0]       redirect_pc_d;
    logic                  busy_d;
    logic                  trap_done_d;

    logic [XLEN-1:0]       tvec_c;
    logic [XLEN-1:0]       handler_pc_c;

    // Handler address from the captured target's tvec; cause bit 31 marks an interrupt.
    always_comb begin
        tvec_c       = cap_to_s_q ? stvec : mtvec;
        handler_pc_c = {tvec_c[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (cap_cause_q[XLEN-1] && (tvec_c[1:0] == TVEC_MODE_VECTORED))
            handler_pc_c = handler_pc_c + (XLEN'(cap_cause_q[CODE_W-1:0]) << 2);
`endif
    end

`ifndef TRAP_VECTORED_EN
    logic unused_tvec_mode;
    assign unused_tvec_mode = ^{tvec_c[1:0], cap_cause_q[XLEN-1]};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, trap capture, and next values of the registered outputs.
    always_comb begin
        state_d             = state_q;
        cap_to_s_d          = cap_to_s_q;
        cap_cause_d         = cap_cause_q;
        cap_tval_d          = cap_tval_q;
        cap_pc_d            = cap_pc_q;
        csr_wr_valid_d      = 1'b0;
        csr_wr_addr_d       = '0;
        csr_wr_data_d       = '0;
        status_trap_valid_d = 1'b0;
        status_trap_to_s_d  = status_trap_to_s;
        priv_new_d          = priv_new;
        redirect_valid_d    = 1'b0;
        redirect_pc_d       = redirect_pc;
        trap_done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (trap_req && sel_valid_c) begin
                    state_d     = EPC;
                    cap_to_s_d  = sel_to_s_c;
                    cap_cause_d = sel_cause_c;
                    cap_tval_d  = sel_tval_c;
                    cap_pc_d    = pc;
                end
            end
            EPC:      if (csr_wr_ready) state_d = CAUSE;
            CAUSE:    if (csr_wr_ready) state_d = TVAL;
            TVAL:     if (csr_wr_ready) state_d = STATUS;
            STATUS:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        case (state_d)
            EPC: begin
                csr_wr_valid_d = 1'b1;
                csr_wr_addr_d  = trap_csr_addr(EPC, cap_to_s_d);
                csr_wr_data_d  = cap_pc_d;
            end
            CAUSE: begin
                csr_wr_valid_d = 1'b1;
                csr_wr_addr_d  = trap_csr_addr(CAUSE, cap_to_s_d);
                csr_wr_data_d  = cap_cause_d;
            end
            TVAL: begin
                csr_wr_valid_d = 1'b1;
                csr_wr_addr_d  = trap_csr_addr(TVAL, cap_to_s_d);
                csr_wr_data_d  = cap_tval_d;
            end
            STATUS: begin
                status_trap_valid_d = 1'b1;
                status_trap_to_s_d  = cap_to_s_d;
                priv_new_d          = cap_to_s_d ? PRIV_S : PRIV_M;
            end
            REDIRECT: begin
                redirect_valid_d = 1'b1;
                trap_done_d      = 1'b1;
                redirect_pc_d    = handler_pc_c;
            end
            default: ;
        endcase
    end

    // Captured trap context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_to_s_q        <= 1'b0;
            cap_cause_q       <= '0;
            cap_tval_q        <= '0;
            cap_pc_q          <= '0;
            csr_wr_valid      <= 1'b0;
            csr_wr_addr       <= '0;
            csr_wr_data       <= '0;
            status_trap_valid <= 1'b0;
            status_trap_to_s  <= 1'b0;
            priv_new          <= PRIV_U;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            busy              <= 1'b0;
            trap_done         <= 1'b0;
        end else begin
            cap_to_s_q        <= cap_to_s_d;
            cap_cause_q       <= cap_cause_d;
            cap_tval_q        <= cap_tval_d;
            cap_pc_q          <= cap_pc_d;
            csr_wr_valid      <= csr_wr_valid_d;
            csr_wr_addr       <= csr_wr_addr_d;
            csr_wr_data       <= csr_wr_data_d;
            status_trap_valid <= status_trap_valid_d;
            status_trap_to_s  <= status_trap_to_s_d;
            priv_new          <= priv_new_d;
            redirect_valid    <= redirect_valid_d;
            redirect_pc       <= redirect_pc_d;
            busy              <= busy_d;
            trap_done         <= trap_done_d;
        end
    end

endmodule

// File: tb/tb_core_trap_sequencer.sv
// Self-checking bench for core_trap_sequencer: directed table, random traps against
// a spec-level model, and hand-written backpressure / ignore / reset sequences.
module tb_core_trap_sequencer;
    import core_pkg::*;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_req;
    logic        exception_valid;
    exception_e  exception_cause;
    logic [31:0] exception_value;
    logic        m_interrupt_valid, s_interrupt_valid;
    interrupt_e  m_interrupt_cause, s_interrupt_cause;
    logic [31:0] pc;
    priv_e       priv;
    logic [31:0] medeleg, mideleg, mtvec, stvec;
    logic        csr_wr_valid;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        csr_wr_ready;
    logic        status_trap_valid, status_trap_to_s;
    priv_e       priv_new;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy, trap_done;

    core_trap_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .trap_req          (trap_req),
        .exception_valid   (exception_valid),
        .exception_cause   (exception_cause),
        .exception_value   (exception_value),
        .m_interrupt_valid (m_interrupt_valid),
        .s_interrupt_valid (s_interrupt_valid),
        .m_interrupt_cause (m_interrupt_cause),
        .s_interrupt_cause (s_interrupt_cause),
        .pc                (pc),
        .priv              (priv),
        .medeleg           (medeleg),
        .mideleg           (mideleg),
        .mtvec             (mtvec),
        .stvec             (stvec),
        .csr_wr_valid      (csr_wr_valid),
        .csr_wr_addr       (csr_wr_addr),
        .csr_wr_data       (csr_wr_data),
        .csr_wr_ready      (csr_wr_ready),
        .status_trap_valid (status_trap_valid),
        .status_trap_to_s  (status_trap_to_s),
        .priv_new          (priv_new),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .busy              (busy),
        .trap_done         (trap_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          exc_v;
        exception_e  exc_cause;
        logic [31:0] exc_val;
        bit          mi_v;
        interrupt_e  mi_cause;
        bit          si_v;
        interrupt_e  si_cause;
        logic [31:0] pc;
        priv_e       priv;
        logic [31:0] medeleg, mideleg, mtvec, stvec;
    } vec_t;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] tval;
        bit          to_s;
        logic [31:0] redir;
    } exp_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } row_t;

    int checks = 0;
    int errors = 0;

    logic [4:0] exc_codes [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                   5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd15};
    logic [4:0] int_codes [6]  = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input bit ev, input logic [4:0] ec, input logic [31:0] eval,
                                 input bit mv, input logic [4:0] mc, input bit sv, input logic [4:0] sc,
                                 input logic [31:0] vpc, input logic [1:0] pr,
                                 input logic [31:0] med, input logic [31:0] mid,
                                 input logic [31:0] mt, input logic [31:0] st);
        vec_t v;
        v.exc_v = ev; v.exc_cause = exception_e'(ec); v.exc_val = eval;
        v.mi_v = mv;  v.mi_cause = interrupt_e'(mc);
        v.si_v = sv;  v.si_cause = interrupt_e'(sc);
        v.pc = vpc;   v.priv = priv_e'(pr);
        v.medeleg = med; v.mideleg = mid; v.mtvec = mt; v.stvec = st;
        return v;
    endfunction

    function automatic exp_t mke(input logic [31:0] c, input logic [31:0] t, input bit s, input logic [31:0] r);
        exp_t e;
        e.cause = c; e.tval = t; e.to_s = s; e.redir = r;
        return e;
    endfunction

    // Reference: architectural trap entry rules, in plain arithmetic.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        int          code;
        bit          intr;
        logic [31:0] tvec, base;
        e.tval = 32'd0;
        intr   = 1'b1;
        if (v.mi_v) begin
            code   = int'(v.mi_cause);
            e.to_s = 1'b0;
        end else if (v.si_v) begin
            code   = int'(v.si_cause);
            e.to_s = v.mideleg[code];
        end else begin
            intr   = 1'b0;
            code   = int'(v.exc_cause);
            e.tval = v.exc_val;
            e.to_s = (v.priv != PRIV_M) && v.medeleg[code];
        end
        e.cause = intr ? (32'h8000_0000 + 32'(code)) : 32'(code);
        tvec    = e.to_s ? v.stvec : v.mtvec;
        base    = tvec - (tvec % 4);
        e.redir = base;
        if (VEC && intr && (tvec % 4) == 1) e.redir = base + 32'(code * 4);
        return e;
    endfunction

    task automatic drive_vec(input vec_t v);
        exception_valid   = v.exc_v;
        exception_cause   = v.exc_cause;
        exception_value   = v.exc_val;
        m_interrupt_valid = v.mi_v;
        m_interrupt_cause = v.mi_cause;
        s_interrupt_valid = v.si_v;
        s_interrupt_cause = v.si_cause;
        pc                = v.pc;
        priv              = v.priv;
        medeleg           = v.medeleg;
        mideleg           = v.mideleg;
        mtvec             = v.mtvec;
        stvec             = v.stvec;
    endtask

    // stall_mode: 0 ready high, 1 random ready, 2 ready low for 3 cycles during CAUSE.
    // e_done < 0 means the redirect cycle is 5 plus observed stall cycles.
    task automatic run_and_check(input string tag, input vec_t v, input exp_t e,
                                 input int stall_mode, input bit hold_req, input int e_done);
        logic [11:0] eb;
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        logic [11:0] pa;
        logic [31:0] pd;
        logic        rdy, prev_stall, done, busy_ok, stable_ok, pulse_ok, st_s;
        priv_e       st_p;
        logic [31:0] rpc;
        int          nw, nst, stalls, cause_lows, dcyc;
        eb = e.to_s ? 12'h140 : 12'h340;
        for (int k = 0; k < 3; k++) begin wa[k] = '0; wd[k] = '0; end
        pa = '0; pd = '0; prev_stall = 0; done = 0; busy_ok = 1; stable_ok = 1; pulse_ok = 1;
        st_s = 0; st_p = PRIV_U; rpc = '0; nw = 0; nst = 0; stalls = 0; cause_lows = 0; dcyc = 0;

        @(negedge clk);
        drive_vec(v);
        trap_req     = 1'b1;
        csr_wr_ready = 1'b1;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            if (!hold_req) trap_req = 1'b0;
            if (!busy) busy_ok = 0;
            if (prev_stall && (!csr_wr_valid || csr_wr_addr != pa || csr_wr_data != pd)) stable_ok = 0;
            case (stall_mode)
                1:       rdy = ($urandom_range(0, 2) != 0);
                2:       rdy = !(csr_wr_valid && csr_wr_addr == eb + 12'd2 && cause_lows < 3);
                default: rdy = 1'b1;
            endcase
            if (stall_mode == 2 && !rdy) cause_lows++;
            csr_wr_ready = rdy;
            if (csr_wr_valid) begin
                if (rdy) begin
                    if (nw < 3) begin wa[nw] = 32'(csr_wr_addr); wd[nw] = csr_wr_data; end
                    nw++;
                end else begin
                    stalls++;
                end
            end
            prev_stall = csr_wr_valid && !rdy;
            pa = csr_wr_addr;
            pd = csr_wr_data;
            if (status_trap_valid) begin nst++; st_s = status_trap_to_s; st_p = priv_new; end
            if (redirect_valid != trap_done) pulse_ok = 0;
            if (redirect_valid) begin done = 1; dcyc = cyc; rpc = redirect_pc; trap_req = 1'b0; end
        end
        csr_wr_ready = 1'b1;

        chk({tag, "_redirect_seen"}, 32'(done), 32'd1);
        chk({tag, "_nwrites"}, 32'(nw), 32'd3);
        chk({tag, "_epc_addr"}, wa[0], 32'(eb + 12'd1));
        chk({tag, "_epc_data"}, wd[0], v.pc);
        chk({tag, "_cause_addr"}, wa[1], 32'(eb + 12'd2));
        chk({tag, "_cause_data"}, wd[1], e.cause);
        chk({tag, "_tval_addr"}, wa[2], 32'(eb + 12'd3));
        chk({tag, "_tval_data"}, wd[2], e.tval);
        chk({tag, "_status_pulses"}, 32'(nst), 32'd1);
        chk({tag, "_status_to_s"}, 32'(st_s), 32'(e.to_s));
        chk({tag, "_priv_new"}, 32'(st_p), 32'(e.to_s ? PRIV_S : PRIV_M));
        chk({tag, "_redirect_pc"}, rpc, e.redir);
        chk({tag, "_done_cycle"}, 32'(dcyc), 32'(e_done < 0 ? 5 + stalls : e_done));
        chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, "_wr_stable"}, 32'(stable_ok), 32'd1);
        chk({tag, "_done_eq_redirect"}, 32'(pulse_ok), 32'd1);

        @(negedge clk);
        chk({tag, "_idle_after"}, 32'({busy, csr_wr_valid, redirect_valid, trap_done}), 32'd0);
        exception_valid   = 1'b0;
        m_interrupt_valid = 1'b0;
        s_interrupt_valid = 1'b0;
    endtask

    row_t tbl [8];

    initial begin
        vec_t v;
        exp_t e;
        logic found, bad;

        tbl[0].v = mkv(1, 5'd2, 32'h0000_0013, 0, 5'd7, 0, 5'd9, 32'h8000_0100, PRIV_M,
                       32'hFFFF_FFFF, 32'h0, 32'h8000_0003, 32'h8020_0000);
        tbl[0].e = mke(32'h0000_0002, 32'h0000_0013, 0, 32'h8000_0000);
        tbl[1].v = mkv(1, 5'd8, 32'h0, 0, 5'd7, 0, 5'd9, 32'h0000_1000, PRIV_U,
                       32'h0000_0100, 32'h0, 32'h8000_0000, 32'h8020_0000);
        tbl[1].e = mke(32'h0000_0008, 32'h0, 1, 32'h8020_0000);
        tbl[2].v = mkv(1, 5'd2, 32'hDEAD_BEEF, 1, 5'd7, 1, 5'd9, 32'h8000_2000, PRIV_S,
                       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8030_0000);
        tbl[2].e = mke(32'h8000_0007, 32'h0, 0, VEC ? 32'h8000_001C : 32'h8000_0000);
        tbl[3].v = mkv(0, 5'd0, 32'h0, 0, 5'd7, 1, 5'd5, 32'h0000_4000, PRIV_S,
                       32'h0, 32'h0000_0020, 32'h8000_0000, 32'h8030_0001);
        tbl[3].e = mke(32'h8000_0005, 32'h0, 1, VEC ? 32'h8030_0014 : 32'h8030_0000);
        tbl[4].v = mkv(0, 5'd0, 32'h0, 0, 5'd7, 1, 5'd1, 32'h0000_5000, PRIV_U,
                       32'h0, 32'h0, 32'h8000_0002, 32'h8030_0001);
        tbl[4].e = mke(32'h8000_0001, 32'h0, 0, 32'h8000_0000);
        tbl[5].v = mkv(1, 5'd13, 32'h1234_5678, 0, 5'd7, 0, 5'd1, 32'h0000_6000, PRIV_S,
                       32'h0000_2000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFD);
        tbl[5].e = mke(32'h0000_000D, 32'h1234_5678, 1, 32'hFFFF_FFFC);
        tbl[6].v = mkv(0, 5'd0, 32'h0, 1, 5'd11, 0, 5'd1, 32'h0000_7000, PRIV_U,
                       32'h0, 32'h0, 32'hFFFF_FFF1, 32'h0);
        tbl[6].e = mke(32'h8000_000B, 32'h0, 0, VEC ? 32'h0000_001C : 32'hFFFF_FFF0);
        tbl[7].v = mkv(1, 5'd9, 32'h0000_00AA, 0, 5'd7, 0, 5'd1, 32'h0000_8000, PRIV_S,
                       32'hFFFF_FDFF, 32'h0, 32'h8000_0000, 32'h8030_0000);
        tbl[7].e = mke(32'h0000_0009, 32'h0000_00AA, 0, 32'h8000_0000);

        rst_n = 1'b0;
        trap_req = 1'b0;
        csr_wr_ready = 1'b1;
        drive_vec(mkv(0, 5'd0, 32'h0, 0, 5'd7, 0, 5'd1, 32'h0, PRIV_M, 32'h0, 32'h0, 32'h0, 32'h0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_wr_valid", 32'(csr_wr_valid), 32'd0);
        chk("reset_wr_addr", 32'(csr_wr_addr), 32'd0);
        chk("reset_status", 32'({status_trap_valid, status_trap_to_s}), 32'd0);
        chk("reset_priv_new", 32'(priv_new), 32'(PRIV_U));
        chk("reset_redirect", 32'({redirect_valid, trap_done, busy}), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);

        for (int i = 0; i < 8; i++)
            run_and_check($sformatf("tbl%0d", i), tbl[i].v, tbl[i].e, 0, 1'b0, 5);

        run_and_check("backpressure", tbl[0].v, tbl[0].e, 2, 1'b0, 8);
        run_and_check("req_while_busy", tbl[1].v, tbl[1].e, 0, 1'b1, 5);

        // trap_req with nothing pending must not start a sequence.
        @(negedge clk);
        trap_req = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            trap_req = 1'b0;
            if (busy || csr_wr_valid || status_trap_valid || redirect_valid) bad = 1;
        end
        chk("no_valid_ignored", 32'(bad), 32'd0);

        // Reset asserted while the TVAL write is outstanding.
        @(negedge clk);
        drive_vec(tbl[0].v);
        trap_req = 1'b1;
        csr_wr_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            trap_req = 1'b0;
            if (csr_wr_valid && csr_wr_addr == 12'h343) found = 1;
        end
        chk("rst_reach_tval", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", 32'({csr_wr_valid, busy}), 32'd0);
        chk("rst_mid_addr", 32'(csr_wr_addr), 32'd0);
        chk("rst_mid_data", csr_wr_data, 32'd0);
        chk("rst_mid_pulses", 32'({status_trap_valid, status_trap_to_s, redirect_valid, trap_done}), 32'd0);
        chk("rst_mid_priv_new", 32'(priv_new), 32'(PRIV_U));
        chk("rst_mid_redirect_pc", redirect_pc, 32'd0);
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (redirect_valid || status_trap_valid || busy) bad = 1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (redirect_valid || status_trap_valid || busy || csr_wr_valid) bad = 1;
        end
        chk("rst_no_pulse", 32'(bad), 32'd0);
        exception_valid = 1'b0;
        run_and_check("after_rst", tbl[0].v, tbl[0].e, 0, 1'b0, 5);

        // Random traps with random backpressure against the reference model.
        for (int n = 0; n < 40; n++) begin
            int vb;
            vb = int'($urandom_range(1, 7));
            v.exc_v     = vb[0];
            v.si_v      = vb[1];
            v.mi_v      = vb[2];
            v.exc_cause = exception_e'(exc_codes[$urandom_range(0, 13)]);
            v.mi_cause  = interrupt_e'(int_codes[$urandom_range(0, 5)]);
            v.si_cause  = interrupt_e'(int_codes[$urandom_range(0, 5)]);
            v.exc_val   = $urandom;
            v.pc        = $urandom;
            case ($urandom_range(0, 2))
                0:       v.priv = PRIV_U;
                1:       v.priv = PRIV_S;
                default: v.priv = PRIV_M;
            endcase
            v.medeleg = $urandom;
            v.mideleg = $urandom;
            v.mtvec   = $urandom;
            v.stvec   = $urandom;
            e = model(v);
            run_and_check($sformatf("rnd%0d", n), v, e, 1, n[0], -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_trap_sequencer.md
# core_trap_sequencer

Multi-cycle controller that turns a trap decision into the architectural trap entry sequence. It sits between the core controller, the trap-cause logic and the CSR file. On each accepted trap it:
- arbitrates between M-interrupt, S-interrupt and exception;
- resolves delegation to M or S mode;
- writes xEPC, xCAUSE and xTVAL over the shared CSR write port;
- commands the xSTATUS stack update and privilege change;
- issues the PC redirect to xTVEC.

## Interface
No parameters.
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `trap_req`  in  1  controller strobe at instruction boundary; cause inputs are held stable until `trap_done`
- `exception_valid`  in  1  exception pending
- `exception_cause`  in  `core_pkg::exception_e`  exception code
- `exception_value`  in  32  tval for exception
- `m_interrupt_valid`, `s_interrupt_valid`  in  1  enabled pending interrupts
- `m_interrupt_cause`, `s_interrupt_cause`  in  `core_pkg::interrupt_e`  interrupt codes
- `pc`  in  32  PC of the trapping or interrupted instruction
- `priv`  in  `core_pkg::priv_e`  current privilege
- `medeleg`, `mideleg`  in  32  delegation CSRs
- `mtvec`, `stvec`  in  32  trap vector CSRs
- `csr_wr_valid`  out  1  CSR write request
- `csr_wr_addr`  out  12  CSR address
- `csr_wr_data`  out  32  write data
- `csr_wr_ready`  in  1  CSR file accepts the write
- `status_trap_valid`  out  1  one-cycle pulse: CSR file performs the xPIE/xIE/xPP stack update
- `status_trap_to_s`  out  1  target of the stack update (1 = S, 0 = M)
- `priv_new`  out  `core_pkg::priv_e`  new privilege, valid with `status_trap_valid`
- `redirect_valid`  out  1  one-cycle pulse: fetch from `redirect_pc`
- `redirect_pc`  out  32  handler address
- `busy`  out  1  sequence in progress
- `trap_done`  out  1  one-cycle pulse, coincident with `redirect_valid`

## Operation
- **Reset values:** every output is 0 and `priv_new` is `PRIV_U`. FSM state is IDLE.
- **Acceptance:** only in IDLE, when `trap_req` is high and at least one of the three valid inputs is high. `trap_req` with no valid, or while `busy`, is ignored.
- **Capture on acceptance:** selected cause, `is_int`, tval, `pc`, and target mode.
- **Priority:** M-interrupt > S-interrupt > exception.
- **Delegation:**
  - M-interrupt is always taken in M.
  - S-interrupt goes to S iff `mideleg[code]` is set; otherwise M.
  - Exception goes to S iff `priv != PRIV_M` and `medeleg[code]` is set; otherwise M.
- **Cause word:** `{is_int, 26'b0, code[4:0]}`.
- **tval:** `exception_value` for exceptions, 0 for interrupts.
- **FSM:** IDLE → EPC → CAUSE → TVAL → STATUS → REDIRECT → IDLE.
  - EPC, CAUSE and TVAL each drive `csr_wr_valid` and advance only on `csr_wr_ready`.
  - Addresses are MEPC/MCAUSE/MTVAL or SEPC/SCAUSE/STVAL according to the captured target.
  - `csr_wr_addr` and `csr_wr_data` stay stable while valid is high without ready.
- **STATUS:** pulses `status_trap_valid` for one cycle; `priv_new` = `PRIV_S` or `PRIV_M`.
- **REDIRECT:** pulses `redirect_valid` and `trap_done`; `redirect_pc` = `{tvec[31:2], 2'b00}`, or the vectored address (see Configuration).
- **Arithmetic:** vector offset is `code << 2`, added mod 2^32.
- **Reset mid-sequence:** returns to IDLE immediately. No redirect or status pulse is emitted; CSR writes already completed stand.

## Timing
- Acceptance in cycle 0 (registered).
- With `csr_wr_ready` tied high:
  - EPC write in cycle 1, CAUSE in cycle 2, TVAL in cycle 3;
  - STATUS in cycle 4;
  - REDIRECT in cycle 5;
  - IDLE in cycle 6, ready for a new `trap_req`.
- Each ready-low cycle during a write adds one cycle.
- `busy` is high in cycles 1–5 inclusive.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- **`TRAP_VECTORED_EN` defined:** when `tvec[1:0]==2'b01` and the trap is an interrupt, `redirect_pc = {tvec[31:2],2'b00} + (code<<2)`. Exceptions always use the base.
- **Undefined:** the mode bits are ignored and all traps go to the base.
- In both builds, modes 2 and 3 behave as direct.

## Structure
- **`core_pkg` additions:**
  - CSR address constants `CSR_MEPC`, `CSR_MCAUSE`, `CSR_MTVAL`, `CSR_SEPC`, `CSR_SCAUSE`, `CSR_STVAL`;
  - `trap_state_e` (IDLE, EPC, CAUSE, TVAL, STATUS, REDIRECT);
  - `TVEC_MODE_VECTORED` = 2'b01.
- **Sub-module `core_trap_select`:** combinational priority, delegation and cause-word formation, instantiated once.

## Test plan
- **M exception:** `priv`=M, illegal instruction (cause 2), `exception_value`=0x00000013, `pc`=0x80000100, ready high → writes 0x341←0x80000100, 0x342←0x00000002, 0x343←0x00000013; `priv_new`=M; `redirect_pc`=`mtvec`&~3 in cycle 5.
- **Delegated exception:** `priv`=U, ecall (cause 8), `medeleg[8]`=1, `stvec`=0x80200000 → writes 0x141/0x142/0x143 (cause 8, tval 0); `status_trap_to_s`=1; redirect 0x80200000.
- **Interrupt priority and vectoring:** M-timer and S-external pending together, `mtvec`=0x80000001, `TRAP_VECTORED_EN` → cause 0x80000007; redirect 0x8000001C (without the macro, 0x80000000).
- **Backpressure:** `csr_wr_ready` low 3 cycles during CAUSE → addr and data stable; `trap_done` in cycle 8.
- **Ignored requests:** `trap_req` with no valid → no activity; second `trap_req` while `busy` → ignored.
- **Reset mid-sequence:** `rst_n` low in TVAL state → all outputs 0 next edge; no `redirect_valid` pulse.
